unsigned_calc: RTL and testbench

//   Fixed-coefficient unsigned arithmetic unit: computes F = 7*A - 3*B + 6*C.
//   A, B and C are 4-bit unsigned operands. The 8-bit result is taken modulo 256.
//   The output is registered, giving one cycle of latency.

---
 rtl/unsigned_calc_pkg.sv | 8 +
 rtl/unsigned_calc_adder.sv | 22 ++
 rtl/unsigned_calc.sv | 87 ++++++++
 tb/tb_unsigned_calc.sv | 109 ++++++++++
 4 files changed

// File: rtl/unsigned_calc_pkg.sv
// Shared widths for the fixed-coefficient unsigned calculator.
// Operands are 4 bits wide; the result is 8 bits, taken modulo 256.
package unsigned_calc_pkg;

    localparam int OP_W  = 4;
    localparam int RES_W = 8;

endpackage

// File: rtl/unsigned_calc_adder.sv
// ripple_adder_8: 8-bit ripple-carry adder made of full-adder cells.
// Ports: a, b (addends), cin (carry in), sum (a+b+cin), cout (carry out).
module ripple_adder_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [8:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[8];

endmodule

// File: rtl/unsigned_calc.sv
// unsigned_calc: registered F = (7A - 3B + 6C) mod 256, one cycle latency.
// Ports: i_clk, i_rst (async high), i_au/i_bu/i_cu (4b operands), o_fu (8b).
module unsigned_calc
    import unsigned_calc_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [OP_W-1:0]  i_au,
    input  logic [OP_W-1:0]  i_bu,
    input  logic [OP_W-1:0]  i_cu,
    output logic [RES_W-1:0] o_fu
);

    logic [RES_W-1:0] a_ext;
    logic [RES_W-1:0] b_ext;
    logic [RES_W-1:0] c_ext;

    logic [RES_W-1:0] a7;
    logic [RES_W-1:0] c6;
    logic [RES_W-1:0] b3;
    logic [RES_W-1:0] ac;
    logic [RES_W-1:0] fu_d;
    logic [RES_W-1:0] fu_q;

    // Carry-outs are unused: everything is taken modulo 256, and the
    // low 8 bits of a wider zero-extended sum are identical.
    logic [4:0] co_unused;

    assign a_ext = RES_W'(i_au);
    assign b_ext = RES_W'(i_bu);
    assign c_ext = RES_W'(i_cu);

    // 7A = 8A + ~A + 1
    ripple_adder_8 u_a7 (
        .a    (a_ext << 3),
        .b    (~a_ext),
        .cin  (1'b1),
        .sum  (a7),
        .cout (co_unused[0])
    );

    // 6C = 4C + 2C
    ripple_adder_8 u_c6 (
        .a    (c_ext << 2),
        .b    (c_ext << 1),
        .cin  (1'b0),
        .sum  (c6),
        .cout (co_unused[1])
    );

    // 3B = 2B + B
    ripple_adder_8 u_b3 (
        .a    (b_ext << 1),
        .b    (b_ext),
        .cin  (1'b0),
        .sum  (b3),
        .cout (co_unused[2])
    );

    ripple_adder_8 u_ac (
        .a    (a7),
        .b    (c6),
        .cin  (1'b0),
        .sum  (ac),
        .cout (co_unused[3])
    );

    // Subtract 3B in two's complement: add ~3B with carry-in 1.
    ripple_adder_8 u_fin (
        .a    (ac),
        .b    (~b3),
        .cin  (1'b1),
        .sum  (fu_d),
        .cout (co_unused[4])
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fu_q <= '0;
        end else begin
            fu_q <= fu_d;
        end
    end

    assign o_fu = fu_q;

endmodule

// File: tb/tb_unsigned_calc.sv
// Randomized and exhaustive streaming bench for unsigned_calc.
// Expected values come from plain integer arithmetic on the operands.
module tb_unsigned_calc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] a   = '0;
    logic [3:0] b   = '0;
    logic [3:0] c   = '0;
    logic [7:0] f;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    unsigned_calc dut (
        .i_clk (clk),
        .i_rst (rst),
        .i_au  (a),
        .i_bu  (b),
        .i_cu  (c),
        .o_fu  (f)
    );

    function automatic logic [7:0] model(int x, int y, int z);
        int r;
        r = 7 * x - 3 * y + 6 * z;
        return 8'(r & 255);
    endfunction

    task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called on a falling edge: check the result of the previous
    // operand set, then apply the next one.
    task automatic step(string tag, int x, int y, int z);
        if (exp_q.size() > 0)
            chk(tag, f, exp_q.pop_front());
        a = 4'(x);
        b = 4'(y);
        c = 4'(z);
        exp_q.push_back(model(x, y, z));
        @(negedge clk);
    endtask

    task automatic drain(string tag);
        while (exp_q.size() > 0)
            chk(tag, f, exp_q.pop_front());
    endtask

    initial begin
        #1;
        chk("reset_init", f, 8'h00);
        @(negedge clk);
        chk("reset_held", f, 8'h00);
        rst = 1'b0;

        step("zero", 0, 0, 0);
        step("all15", 15, 15, 15);
        step("max", 15, 0, 15);
        step("small", 1, 2, 4);
        step("min", 0, 15, 0);
        drain("min");
        chk("dir_max", model(15, 0, 15), 8'd195);

        for (int i = 0; i < 4096; i++)
            step("exh", i >> 8, (i >> 4) & 15, i & 15);
        drain("exh");

        for (int i = 0; i < 500; i++)
            step("rand", $urandom_range(15), $urandom_range(15),
                 $urandom_range(15));
        drain("rand");

        // Async reset mid-run: output clears with no clock edge.
        a = 4'd9;
        b = 4'd1;
        c = 4'd3;
        @(negedge clk);
        chk("pre_rst", f, model(9, 1, 3));
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async", f, 8'h00);
        @(negedge clk);
        chk("rst_hold", f, 8'h00);
        rst = 1'b0;
        step("post_rst", 15, 0, 15);
        drain("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got 0 expected 1");
        $fatal(1);
    end

endmodule
